// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: widths, funct3 size/sign codes,
// FSM state type and the size-to-offset-mask helper.
package lsu_pkg;

    localparam int XLEN_W     = 64;
    localparam int RS_W       = 5;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

    // Offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data shift and load shift plus
// sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        offset_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [XLEN-1:0]   ld_raw_i,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   st_data_o,
    output logic [XLEN-1:0]   ld_data_o
);
    localparam int NB = XLEN / 8;

    logic [NB-1:0]   base_strb;
    logic [XLEN-1:0] ld_sh;

    always_comb begin
        base_strb = '0;
        case (funct3_i[1:0])
            2'b00:   base_strb = NB'(8'h01);
            2'b01:   base_strb = NB'(8'h03);
            2'b10:   base_strb = NB'(8'h0F);
            default: base_strb = NB'(8'hFF);
        endcase
    end

    assign wstrb_o   = base_strb << offset_i;
    assign st_data_o = st_data_i << {offset_i, 3'b000};
    assign ld_sh     = ld_raw_i >> {offset_i, 3'b000};

    always_comb begin
        ld_data_o = ld_sh;
        case (funct3_i)
            F3_LB:   ld_data_o = {{(XLEN-8){ld_sh[7]}},   ld_sh[7:0]};
            F3_LH:   ld_data_o = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
            F3_LW:   ld_data_o = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
            F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}},  ld_sh[7:0]};
            F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
            F3_LWU:  ld_data_o = {{(XLEN-32){1'b0}}, ld_sh[31:0]};
            default: ld_data_o = ld_sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit feeding the register-file write port over a valid/ready bus.
// Optional misaligned-access trap: define YSYX_23060251_MISALIGN_TRAP_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_load_i,
    input  logic                  req_is_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [XLEN-1:0]       req_addr_i,
    input  logic [XLEN-1:0]       req_wdata_i,
    input  logic                  req_wen_i,
    input  logic [REG_ADDR_W-1:0] req_rd_i,
    input  logic [XLEN-1:0]       req_e_wdata_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [XLEN/8-1:0]     mem_wstrb_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [XLEN-1:0]       mem_rsp_data_i,
    input  logic                  mem_rsp_err_i,
    output logic                  wb_valid_o,
    output logic                  wb_wen_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  wb_is_load_o,
    output logic [XLEN-1:0]       wb_e_wdata_o,
    output logic [XLEN-1:0]       wb_m_wdata_o,
    output logic                  err_o
);
    lsu_state_e state_q, state_d;

    logic                  is_load_q, is_store_q, wen_q, err_q;
    logic [2:0]            funct3_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [XLEN-1:0]       wdata_q, e_wdata_q, rdata_q;
    logic [REG_ADDR_W-1:0] rd_q;

    logic                  accept, is_mem_in, misalign_in;
    logic [2:0]            eff_off;
    logic [XLEN/8-1:0]     strb_al;
    logic [XLEN-1:0]       wdata_al, ld_ext;
    logic                  unused_addr_hi;

    assign unused_addr_hi = &{1'b0, req_addr_i[XLEN-1:ADDR_W]};

    assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign is_mem_in   = req_is_load_i || req_is_store_i;

`ifdef YSYX_23060251_MISALIGN_TRAP_EN
    assign misalign_in = is_mem_in && |(req_addr_i[2:0] & size_mask(req_funct3_i));
    assign eff_off     = addr_q[2:0];
`else
    // Without the trap the access is silently aligned down to its natural boundary.
    assign misalign_in = 1'b0;
    assign eff_off     = addr_q[2:0] & ~size_mask(funct3_q);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) state_d = (is_mem_in && !misalign_in) ? ST_REQ : ST_WB;
            ST_REQ:  if (mem_req_ready_i) state_d = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid_i) state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            e_wdata_q  <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
        end else if (accept) begin
            is_load_q  <= req_is_load_i;
            is_store_q <= req_is_store_i;
            wen_q      <= req_wen_i;
            err_q      <= misalign_in;
            funct3_q   <= req_funct3_i;
            addr_q     <= req_addr_i[ADDR_W-1:0];
            wdata_q    <= req_wdata_i;
            e_wdata_q  <= req_e_wdata_i;
            rdata_q    <= '0;
            rd_q       <= req_rd_i;
        end else if (state_q == ST_WAIT && mem_rsp_valid_i) begin
            rdata_q <= mem_rsp_data_i;
            err_q   <= mem_rsp_err_i;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i  (funct3_q),
        .offset_i  (eff_off),
        .st_data_i (wdata_q),
        .ld_raw_i  (rdata_q),
        .wstrb_o   (strb_al),
        .st_data_o (wdata_al),
        .ld_data_o (ld_ext)
    );

    // Bus and write-back fields are zero outside their own state so idle buses stay quiet.
    always_comb begin
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_wstrb_o     = '0;
        if (state_q == ST_REQ) begin
            mem_req_valid_o = 1'b1;
            mem_we_o        = is_store_q;
            mem_addr_o      = {addr_q[ADDR_W-1:3], 3'b000};
            mem_wdata_o     = wdata_al;
            mem_wstrb_o     = strb_al;
        end
    end

    always_comb begin
        wb_valid_o   = 1'b0;
        wb_wen_o     = 1'b0;
        wb_rd_o      = '0;
        wb_is_load_o = 1'b0;
        wb_e_wdata_o = '0;
        wb_m_wdata_o = '0;
        err_o        = 1'b0;
        if (state_q == ST_WB) begin
            wb_valid_o   = 1'b1;
            wb_wen_o     = wen_q && !is_store_q && !err_q;
            wb_rd_o      = rd_q;
            wb_is_load_o = is_load_q;
            wb_e_wdata_o = e_wdata_q;
            wb_m_wdata_o = is_load_q ? ld_ext : '0;
            err_o        = err_q;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with hand-computed expected values.
module tb_lsu;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_is_load, req_is_store, req_wen;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr, req_wdata, req_e_wdata;
    logic [4:0]        req_rd;
    logic              mem_req_valid, mem_req_ready, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [7:0]        mem_wstrb;
    logic              mem_rsp_valid, mem_rsp_err;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              wb_valid, wb_wen, wb_is_load, err;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_e_wdata, wb_m_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_is_load_i(req_is_load), .req_is_store_i(req_is_store),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wen_i(req_wen), .req_rd_i(req_rd), .req_e_wdata_i(req_e_wdata),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i(mem_rsp_data), .mem_rsp_err_i(mem_rsp_err),
        .wb_valid_o(wb_valid), .wb_wen_o(wb_wen), .wb_rd_o(wb_rd),
        .wb_is_load_o(wb_is_load), .wb_e_wdata_o(wb_e_wdata),
        .wb_m_wdata_o(wb_m_wdata), .err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic wen, input logic [4:0] rd, input logic [63:0] ew);
        req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_wen = wen; req_rd = rd; req_e_wdata = ew;
        check("req_ready_before_accept", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    // Runs one bus transaction already accepted and now in the request phase.
    task automatic bus_phase(input string tag, input int stall, input logic exp_we,
                             input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                             input logic [63:0] exp_wdata, input logic [63:0] rsp,
                             input logic rerr);
        for (int i = 0; i <= stall; i++) begin
            check({tag, "_req_valid"}, mem_req_valid, 1'b1);
            check({tag, "_we"}, mem_we, exp_we);
            check({tag, "_addr"}, mem_addr, exp_addr);
            check({tag, "_strb"}, mem_wstrb, exp_strb);
            check({tag, "_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_no_wb_in_req"}, wb_valid, 1'b0);
            if (i == stall) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        check({tag, "_req_drop_in_wait"}, mem_req_valid, 1'b0);
        mem_rsp_valid = 1'b1; mem_rsp_data = rsp; mem_rsp_err = rerr;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic check_wb(input string tag, input logic wen, input logic [4:0] rd,
                            input logic isld, input logic [63:0] ew, input logic [63:0] mw,
                            input logic e);
        check({tag, "_wb_valid"}, wb_valid, 1'b1);
        check({tag, "_wb_wen"}, wb_wen, wen);
        check({tag, "_wb_rd"}, wb_rd, rd);
        check({tag, "_wb_is_load"}, wb_is_load, isld);
        check({tag, "_wb_e_wdata"}, wb_e_wdata, ew);
        check({tag, "_wb_m_wdata"}, wb_m_wdata, mw);
        check({tag, "_err"}, err, e);
        tick();
        check({tag, "_wb_pulse_ends"}, wb_valid, 1'b0);
        check({tag, "_ready_after_wb"}, req_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0; req_wen = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0; req_e_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wstrb", mem_wstrb, 8'h00);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_wb_m_wdata", wb_m_wdata, 64'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst_release", req_ready, 1'b1);

        // Pass-through ALU op: write-back exactly one cycle after accept.
        issue(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 1'b1, 5'd5, 64'h1234);
        check("alu_no_bus", mem_req_valid, 1'b0);
        check_wb("alu", 1'b1, 5'd5, 1'b0, 64'h1234, 64'h0, 1'b0);

        // lbu at offset 3
        issue(1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'h0, 1'b1, 5'd10, 64'hAA);
        bus_phase("lbu", 0, 1'b0, 32'h8000_0000, 8'h08, 64'h0,
                  64'h1122_3344_5566_7788, 1'b0);
        check_wb("lbu", 1'b1, 5'd10, 1'b1, 64'hAA, 64'h55, 1'b0);

        // lh at offset 6, negative halfword
        issue(1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'h0, 1'b1, 5'd11, 64'h0);
        bus_phase("lh", 0, 1'b0, 32'h8000_0000, 8'hC0, 64'h0,
                  64'h8001_0000_0000_0000, 1'b0);
        check_wb("lh", 1'b1, 5'd11, 1'b0 | 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);

        // sw at offset 4 with the bus stalling three cycles
        issue(1'b0, 1'b1, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 1'b1, 5'd12, 64'h0);
        bus_phase("sw", 3, 1'b1, 32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000,
                  64'h0, 1'b0);
        check_wb("sw", 1'b0, 5'd12, 1'b0, 64'h0, 64'h0, 1'b0);

        // lwu at offset 4: zero extension of a negative word
        issue(1'b1, 1'b0, 3'b110, 64'h8000_0104, 64'h0, 1'b1, 5'd13, 64'h0);
        bus_phase("lwu", 0, 1'b0, 32'h8000_0100, 8'hF0, 64'h0,
                  64'h8765_4321_0000_0000, 1'b0);
        check_wb("lwu", 1'b1, 5'd13, 1'b1, 64'h0, 64'h0000_0000_8765_4321, 1'b0);

        // lw at offset 2
        issue(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0, 1'b1, 5'd14, 64'h77);
`ifdef YSYX_23060251_MISALIGN_TRAP_EN
        check("lw_mis_no_bus", mem_req_valid, 1'b0);
        check_wb("lw_mis", 1'b0, 5'd14, 1'b1, 64'h77, 64'h0, 1'b1);
`else
        bus_phase("lw_al", 0, 1'b0, 32'h8000_0000, 8'h0F, 64'h0,
                  64'h1122_3344_5566_7788, 1'b0);
        check_wb("lw_al", 1'b1, 5'd14, 1'b1, 64'h77, 64'h0000_0000_5566_7788, 1'b0);
`endif

        // Bus error on ld: wen suppressed, other fields still captured
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'h0, 1'b1, 5'd15, 64'h99);
        bus_phase("ld_err", 1, 1'b0, 32'h8000_0008, 8'hFF, 64'h0,
                  64'h0123_4567_89AB_CDEF, 1'b1);
        check_wb("ld_err", 1'b0, 5'd15, 1'b1, 64'h99, 64'h0123_4567_89AB_CDEF, 1'b1);

        // Reset while waiting for a response; the late response must be ignored
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 1'b1, 5'd16, 64'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rstwait_ready_in_rst", req_ready, 1'b0);
        check("rstwait_req_valid", mem_req_valid, 1'b0);
        check("rstwait_wb_valid", wb_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("rstwait_ready_after", req_ready, 1'b1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        check("late_rsp_no_wb", wb_valid, 1'b0);
        check("late_rsp_no_err", err, 1'b0);
        check("late_rsp_ready", req_ready, 1'b1);
        tick();
        check("late_rsp_no_wb2", wb_valid, 1'b0);

        issue(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 1'b1, 5'd17, 64'h0);
        bus_phase("ld", 0, 1'b0, 32'h8000_0010, 8'hFF, 64'h0,
                  64'hCAFE_BABE_1234_5678, 1'b0);
        check_wb("ld", 1'b1, 5'd17, 1'b1, 64'h0, 64'hCAFE_BABE_1234_5678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the register-file write port. It accepts one instruction per transaction from execute and runs the memory access over a valid/ready data bus. It aligns store data and strobes, then shifts and sign- or zero-extends load data. It presents the write-back fields `wen`, `rd`, `e_wdata`, `is_load` and `m_wdata` to the register file as a single-cycle pulse.

## Interface
Parameters:
- XLEN, 64, datapath/register width; bus data width equals XLEN
- ADDR_W, 32, bus address width

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  1  execute presents an instruction
- req_ready_o  out  1  LSU can accept; high only in IDLE
- req_is_load_i / req_is_store_i  in  1  memory-op class; both low = pass-through
- req_funct3_i  in  3  size/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- req_addr_i  in  XLEN  effective address
- req_wdata_i  in  XLEN  store data, LSB-justified
- req_wen_i  in  1  register write enable from decode
- req_rd_i  in  5  destination register
- req_e_wdata_i  in  XLEN  ALU result
- mem_req_valid_o  out  1  bus request valid
- mem_req_ready_i  in  1  bus accepts request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  ADDR_W  req_addr_i[ADDR_W-1:0] with the low 3 bits cleared
- mem_wdata_o  out  XLEN  store data shifted to the lane
- mem_wstrb_o  out  XLEN/8  byte strobes
- mem_rsp_valid_i  in  1  response valid, for loads and stores
- mem_rsp_data_i  in  XLEN  raw aligned doubleword
- mem_rsp_err_i  in  1  bus error, qualified by mem_rsp_valid_i
- wb_valid_o  out  1  write-back pulse, one cycle
- wb_wen_o, wb_rd_o, wb_is_load_o, wb_e_wdata_o, wb_m_wdata_o  out  1/5/1/XLEN/XLEN  register-file write fields
- err_o  out  1  access fault pulse, coincident with wb_valid_o

## Operation
- FSM states are IDLE, REQ, WAIT and WB.
- IDLE: a handshake (req_valid_i & req_ready_o) captures every req_* field.
  - Pass-through instruction: go to WB.
  - Load or store: go to REQ.
- REQ: mem_req_valid_o is high and its fields are stable until mem_req_ready_i. On the handshake, go to WAIT.
- WAIT: on mem_rsp_valid_i, capture the data and error, then go to WB. A response is sampled only in WAIT; in any other state it is ignored.
- WB: wb_valid_o is high for one cycle, then the FSM returns to IDLE.
- Offset o = addr[2:0]; size s = 1/2/4/8 from funct3[1:0].
- mem_wstrb_o = ((1<<s)-1) << o.
- mem_wdata_o = wdata << 8·o.
- Load: rdata >> 8·o, truncated to s bytes. Sign-extend when funct3[2]=0, zero-extend otherwise.
- wb_is_load_o = captured is_load.
- wb_wen_o = captured wen, forced to 0 for stores and on error.
- wb_m_wdata_o = extended load data; 0 for non-loads.
- On error: err_o=1, wb_wen_o=0; the other wb fields still carry the captured values.
- The LSU does not special-case rd=0; the register file ignores it.

## Timing
- Reset values: state IDLE.
  - Outputs low: req_ready_o, mem_req_valid_o, wb_valid_o, err_o.
  - All data, address, strobe and wb_* buses are 0.
- req_ready_o is high from the first cycle after reset release.
- Pass-through: accept at T, wb_valid_o at T+1.
- Memory op: accept at T, mem_req_valid_o from T+1. Bus handshake at T+1+k, response at T+2+k+m (m≥0 cycles after entering WAIT), wb_valid_o one cycle after the response.
  - Minimum load/store latency is 3 cycles.
- No new request is accepted until the cycle after WB.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values. An outstanding bus request is abandoned, and a stale response arriving later is ignored.
- Response valid with err in the same cycle: the error takes priority.

## Configuration
- YSYX_23060251_MISALIGN_TRAP_EN defined:
  - When o is not a multiple of s, no bus request is issued.
  - The FSM goes IDLE→WB, wb_valid_o fires at T+1 with err_o=1 and wb_wen_o=0.
- Undefined:
  - The low log2(s) bits of the offset are cleared before strobe/shift generation, so the access is silently aligned downward.
  - err_o is raised only by mem_rsp_err_i.

## Structure
- The shared defines/package holds:
  - funct3 size/sign encodings
  - LSU state encoding
  - the existing rs/reg/xlen bus width macros
- Sub-module lsu_align: combinational strobe/store-shift and load-shift/extend logic, instantiated once.

## Test plan
- lbu, addr=0x8000_0003, rsp_data=0x1122_3344_5566_7788 -> mem_addr_o=0x8000_0000, wb_m_wdata_o=0x55, wb_wen_o=1, wb_is_load_o=1.
- lh, addr offset 6, rsp_data=0x8001_0000_0000_0000 -> wb_m_wdata_o=0xFFFF_FFFF_FFFF_8001.
- sw, addr offset 4, wdata=0xDEADBEEF -> mem_wstrb_o=0xF0, mem_wdata_o=0xDEADBEEF_0000_0000, wb_wen_o=0; hold mem_req_ready_i low 3 cycles -> request fields stable throughout.
- ALU op with e_wdata=0x1234, rd=5 -> wb_valid_o exactly one cycle after accept, wb_wen_o=1, wb_m_wdata_o=0, no bus activity.
- lw at offset 2:
  - With the macro: err_o=1, wb_wen_o=0, mem_req_valid_o never rises.
  - Without the macro: access aligned to offset 0.
- Reset in WAIT, then a late mem_rsp_valid_i -> no wb_valid_o, req_ready_o=1; a following ld completes normally.
